// File: rtl/mem_stage.sv
// mem_stage: MEM stage -- waits for load responses, aligns load data, feeds WB and ID stall/forward buses.
// Optional MS_RDATA_BUF_EN: buffers the head's load response so a stalled WB need not see data_ok again.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 163,
   parameter int MS_TO_WS_BUS_WD = 126,
   parameter int DISCARD_W       = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_allowin,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [10:0]                stall_ms_bus,
   output logic [33:0]                forward_ms_bus
);
   logic                       ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
   logic [DISCARD_W-1:0]       discard_cnt;
   logic [DISCARD_W-1:0]       discard_nxt;
   logic                       got_resp;
   logic [31:0]                rd;
   logic                       mem_req;
   logic                       exc;
   logic                       res_from_mem;
   logic [2:0]                 load_op;
   logic [1:0]                 off;
   logic [3:0]                 gr_we;
   logic [4:0]                 dest;
   logic [31:0]                alu_result;
   logic [31:0]                rt_value;
   logic                       resp_head;
   logic                       outstanding;
   logic                       wait_resp;
   logic                       ms_ready_go;
   logic                       capture;
   logic                       inc;
   logic                       dec;
   logic [7:0]                 ld_byte;
   logic [15:0]                ld_half;
   logic [31:0]                lwl;
   logic [31:0]                lwr;
   logic [31:0]                load_data;
   logic [31:0]                final_result;

   assign mem_req      = ms_bus[96];
   assign load_op      = ms_bus[99:97];
   assign res_from_mem = ms_bus[100];
   assign dest         = ms_bus[105:101];
   assign gr_we        = ms_bus[109:106];
   assign exc          = ms_bus[129];
   assign alu_result   = ms_bus[95:64];
   assign rt_value     = ms_bus[63:32];
   assign off          = alu_result[1:0];

   // A data_ok belongs to the head only once every orphaned response has drained.
   assign resp_head   = data_sram_data_ok && discard_cnt == '0;
   assign outstanding = ms_valid && mem_req && !got_resp;
   assign wait_resp   = outstanding && !exc && !resp_head;
   assign ms_ready_go = !wait_resp;
   assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
   assign capture     = es_to_ms_valid && ms_allowin;
   assign inc         = flush && outstanding && !resp_head;
   assign dec         = data_sram_data_ok && discard_cnt != '0;

   always_comb begin
      discard_nxt = inc && !dec ? (&discard_cnt ? discard_cnt : discard_cnt + 1'b1) :
                    dec && !inc ? discard_cnt - 1'b1 : discard_cnt;
      ld_byte = 8'(rd >> {off, 3'b000});
      ld_half = off[1] ? rd[31:16] : rd[15:0];
      lwl = off == 2'd0 ? {rd[7:0], rt_value[23:0]} :
            off == 2'd1 ? {rd[15:0], rt_value[15:0]} :
            off == 2'd2 ? {rd[23:0], rt_value[7:0]} : rd;
      lwr = off == 2'd0 ? rd :
            off == 2'd1 ? {rt_value[31:24], rd[31:8]} :
            off == 2'd2 ? {rt_value[31:16], rd[31:16]} : {rt_value[31:8], rd[31:24]};
      load_data = load_op == 3'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                  load_op == 3'd2 ? {24'd0, ld_byte} :
                  load_op == 3'd3 ? {{16{ld_half[15]}}, ld_half} :
                  load_op == 3'd4 ? {16'd0, ld_half} :
                  load_op == 3'd5 ? lwl :
                  load_op == 3'd6 ? lwr : rd;
      final_result = res_from_mem ? load_data : alu_result;
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         ms_valid    <= 1'b0;
         ms_bus      <= '0;
         discard_cnt <= '0;
      end else begin
         ms_valid    <= flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
         if (capture) ms_bus <= es_to_ms_bus;
         discard_cnt <= discard_nxt;
      end

`ifdef MS_RDATA_BUF_EN
   logic [31:0] rdata_buf;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         got_resp  <= 1'b0;
         rdata_buf <= '0;
      end else if (capture) begin
         got_resp  <= 1'b0;
      end else if (outstanding && !exc && resp_head) begin
         got_resp  <= 1'b1;
         rdata_buf <= data_sram_rdata;
      end
   assign rd = got_resp ? rdata_buf : data_sram_rdata;
`else
   assign got_resp = 1'b0;
   assign rd       = data_sram_rdata;
`endif

   assign ms_to_ws_bus   = {ms_bus[162:101], final_result, ms_bus[31:0]};
   assign stall_ms_bus   = {ms_valid & |gr_we, gr_we & {4{ms_valid}}, dest,
                            ms_valid & res_from_mem & !ms_ready_go};
   assign forward_ms_bus = {ms_valid, ms_valid & ms_ready_go, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_mem_stage;
   logic         clk = 1'b0;
   logic         resetn, flush, es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
   logic         data_sram_data_ok;
   logic [162:0] es_to_ms_bus;
   logic [125:0] ms_to_ws_bus;
   logic [31:0]  data_sram_rdata;
   logic [10:0]  stall_ms_bus;
   logic [33:0]  forward_ms_bus;
   int           tests = 0;
   int           fails = 0;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  off;
      logic        rfm;
      logic [31:0] rd;
      logic [31:0] rt;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[10];

   logic [162:0] m_bus;
   logic         m_valid;
   int           m_orph;
   logic         r_mem, r_rfm, r_exc, needs, rmine, rdy, ev, ea;
   logic [31:0]  fin;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .resetn(resetn), .flush(flush), .es_to_ms_valid(es_to_ms_valid),
      .es_to_ms_bus(es_to_ms_bus), .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .stall_ms_bus(stall_ms_bus), .forward_ms_bus(forward_ms_bus)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [162:0] mk(input logic [2:0] op, input logic [1:0] off,
                                       input logic mem, input logic rfm, input logic exc,
                                       input logic [31:0] rt, input logic [31:0] alu_hi,
                                       input logic [3:0] we, input logic [4:0] dest,
                                       input logic [31:0] pc);
      return {pc ^ 32'h5A5A_F0F0, pc[2], exc, pc[11:4], 1'b0, 1'b0, 1'b0, pc[19:12],
              we, dest, rfm, op, mem, {alu_hi[31:2], off}, rt, pc};
   endfunction

   // Reference alignment built from byte-lane shifts and masks.
   function automatic logic [31:0] align(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] rd, input logic [31:0] rt);
      int s;
      logic [31:0] v;
      case (op)
         3'd1: begin v = rd >> (8 * off); return {{24{v[7]}}, v[7:0]}; end
         3'd2: begin v = rd >> (8 * off); return {24'd0, v[7:0]}; end
         3'd3: begin v = rd >> (16 * off[1]); return {{16{v[15]}}, v[15:0]}; end
         3'd4: begin v = rd >> (16 * off[1]); return {16'd0, v[15:0]}; end
         3'd5: begin s = 8 * (3 - off); return (rd << s) | (rt & ((32'h1 << s) - 1)); end
         3'd6: begin s = 8 * off; return (rd >> s) | (rt & ~(32'hFFFF_FFFF >> s)); end
         default: return rd;
      endcase
   endfunction

   task automatic load_lw(input logic [31:0] pc);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_1000, 4'hF, 5'd7, pc);
      tick;
      es_to_ms_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3'd0, 2'd0, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678};
      vecs[1] = '{3'd1, 2'd3, 1'b1, 32'h80FF_0011, 32'h0, 32'hFFFF_FF80};
      vecs[2] = '{3'd2, 2'd3, 1'b1, 32'h80FF_0011, 32'h0, 32'h0000_0080};
      vecs[3] = '{3'd3, 2'd2, 1'b1, 32'h80FF_0011, 32'h0, 32'hFFFF_80FF};
      vecs[4] = '{3'd4, 2'd2, 1'b1, 32'h80FF_0011, 32'h0, 32'h0000_80FF};
      vecs[5] = '{3'd5, 2'd1, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344};
      vecs[6] = '{3'd6, 2'd1, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h11AA_BBCC};
      vecs[7] = '{3'd5, 2'd0, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344};
      vecs[8] = '{3'd6, 2'd3, 1'b1, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA};
      vecs[9] = '{3'd1, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0000_1002};

      resetn = 1'b0; flush = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      ws_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
      repeat (2) tick;
      chk("reset_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("reset_allowin", 128'(ms_allowin), 128'(1'b1));
      chk("reset_stall", 128'(stall_ms_bus), 128'(0));
      chk("reset_fwd", 128'(forward_ms_bus), 128'(0));
      chk("reset_discard", 128'(dut.discard_cnt), 128'(0));
      resetn = 1'b1;
      tick;

      foreach (vecs[i]) begin
         es_to_ms_valid = 1'b1;
         es_to_ms_bus = mk(vecs[i].op, vecs[i].off, vecs[i].rfm, vecs[i].rfm, 1'b0,
                           vecs[i].rt, 32'h0000_1000, 4'h1, 5'd3, 32'h100 + 32'(i));
         tick;
         es_to_ms_valid = 1'b0;
         data_sram_data_ok = vecs[i].rfm;
         data_sram_rdata = vecs[i].rd;
         @(negedge clk);
         chk("vec_valid", 128'(ms_to_ws_valid), 128'(1'b1));
         chk("vec_result", 128'(ms_to_ws_bus[63:32]), 128'(vecs[i].exp));
         tick;
         data_sram_data_ok = 1'b0;
      end

      load_lw(32'h200);
      @(negedge clk);
      chk("lw_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("lw_wait_pending", 128'(stall_ms_bus[0]), 128'(1'b1));
      chk("lw_wait_allowin", 128'(ms_allowin), 128'(1'b0));
      tick;
      @(negedge clk);
      chk("lw_wait2_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      tick;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("lw_done_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("lw_done_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h1234_5678));
      chk("lw_done_pending", 128'(stall_ms_bus[0]), 128'(1'b0));
      tick;
      data_sram_data_ok = 1'b0;

      load_lw(32'h300);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      tick;
      flush = 1'b0;
      chk("flush_wait_discard", 128'(dut.discard_cnt), 128'(1));
      chk("flush_wait_msvalid", 128'(forward_ms_bus[33]), 128'(1'b0));
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_2000, 4'hF, 5'd9, 32'h304);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("orphan_drop_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("orphan_drop_allowin", 128'(ms_allowin), 128'(1'b1));
      tick;
      es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0;
      chk("orphan_drained", 128'(dut.discard_cnt), 128'(0));
      @(negedge clk);
      chk("next_lw_waits", 128'(ms_to_ws_valid), 128'(1'b0));
      tick;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("next_lw_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("next_lw_result", 128'(ms_to_ws_bus[63:32]), 128'(32'hCAFE_F00D));
      tick;
      data_sram_data_ok = 1'b0;

      load_lw(32'h400);
      flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("flush_ok_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      tick;
      flush = 1'b0; data_sram_data_ok = 1'b0;
      chk("flush_ok_discard", 128'(dut.discard_cnt), 128'(0));
      chk("flush_ok_msvalid", 128'(forward_ms_bus[33]), 128'(1'b0));

      load_lw(32'h500);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      load_lw(32'h504);
      chk("pre_reset_discard", 128'(dut.discard_cnt), 128'(1));
      chk("pre_reset_msvalid", 128'(forward_ms_bus[33]), 128'(1'b1));
      #2 resetn = 1'b0;
      #1;
      chk("async_discard", 128'(dut.discard_cnt), 128'(0));
      chk("async_allowin", 128'(ms_allowin), 128'(1'b1));
      chk("async_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("async_stall", 128'(stall_ms_bus), 128'(0));
      chk("async_fwd", 128'(forward_ms_bus), 128'(0));
      tick;
      resetn = 1'b1;

`ifdef MS_RDATA_BUF_EN
      ws_allowin = 1'b0;
      load_lw(32'h600);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("buf_ok_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("buf_ok_allowin", 128'(ms_allowin), 128'(1'b0));
      tick;
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      @(negedge clk);
      chk("buf_hold_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("buf_hold_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0BAD_F00D));
      ws_allowin = 1'b1;
      tick;
      @(negedge clk);
      chk("buf_sent_msvalid", 128'(forward_ms_bus[33]), 128'(1'b0));
      tick;
`endif

      m_bus = '0; m_valid = 1'b0; m_orph = 0;
      for (int c = 0; c < 3000; c++) begin
         r_exc = $urandom_range(0, 15) == 0;
         r_mem = !r_exc && $urandom_range(0, 1) == 1;
         r_rfm = r_mem && $urandom_range(0, 2) != 0;
         es_to_ms_valid = $urandom_range(0, 2) != 0;
         es_to_ms_bus = mk(3'($urandom_range(0, 6)), 2'($urandom), r_mem, r_rfm, r_exc,
                           $urandom, $urandom, 4'($urandom), 5'($urandom), $urandom);
         needs = m_valid && m_bus[96] && !m_bus[129];
         flush = $urandom_range(0, 11) == 0 && m_orph < 2;
         data_sram_data_ok = (m_orph > 0 || needs) && $urandom_range(0, 2) == 0;
         data_sram_rdata = $urandom;
         rmine = data_sram_data_ok && m_orph == 0;
         rdy = !needs || rmine;
         ev = m_valid && rdy && !flush;
         ea = !m_valid || rdy;
         fin = m_bus[100] ? align(m_bus[99:97], m_bus[65:64], data_sram_rdata, m_bus[63:32])
                          : m_bus[95:64];
         @(negedge clk);
         chk("rnd_valid", 128'(ms_to_ws_valid), 128'(ev));
         chk("rnd_allowin", 128'(ms_allowin), 128'(ea));
         chk("rnd_stall", 128'(stall_ms_bus),
             128'({m_valid && |m_bus[109:106], m_bus[109:106] & {4{m_valid}}, m_bus[105:101],
                   m_valid && m_bus[100] && !rdy}));
         if (ev) chk("rnd_ws_bus", 128'(ms_to_ws_bus), 128'({m_bus[162:101], fin, m_bus[31:0]}));
         if (m_valid) chk("rnd_fwd", 128'(forward_ms_bus), 128'({1'b1, rdy, fin}));
         tick;
         if (data_sram_data_ok && m_orph > 0) m_orph--;
         if (flush && needs && !rmine) m_orph++;
         if (es_to_ms_valid && ea) m_bus = es_to_ms_bus;
         m_valid = flush ? 1'b0 : (ea ? es_to_ms_valid : m_valid);
      end
      flush = 1'b0; es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
